// File: rtl/neuron_learn_layer_seq_pkg.sv
// Shared definitions for the sequential learning layer.
//   zero2one_t    : unsigned activation in [0,1), ZW bits
//   frac_t        : signed fixed-point weight, FW bits
//   layer_state_t : transaction FSM states
//   avg_acc_w()   : column accumulator width for an M-way average
//   avg_idx_w()   : index counter width for an M-way average
package neuron_learn_layer_seq_pkg;

    localparam int unsigned ZW = 8;
    localparam int unsigned FW = 16;

    typedef logic [ZW-1:0]        zero2one_t;
    typedef logic signed [FW-1:0] frac_t;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT,
        REDUCE,
        DONE
    } layer_state_t;

    // Sum of m values of ZW bits never exceeds ZW+clog2(m) bits.
    function automatic int unsigned avg_acc_w(input int unsigned m);
        return ZW + $clog2(m);
    endfunction

    function automatic int unsigned avg_idx_w(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/neuron_learn.sv
// Single learning neuron (reference stand-in used by the layer).
//   i_clock          : rising-edge clock (no reset: weights persist)
//   i_valid          : evaluate pulse; results register on this edge
//   i_learn          : apply a learn step with this evaluation
//   i_in             : N inputs
//   i_expected_out   : training target
//   o_out            : mean of inputs
//   o_expected_in    : un-averaged back-propagated targets per input
//   o_weights        : per-input weights
//   o_activation_max : largest activation seen
//   o_activation_min : smallest activation seen
module neuron_learn
    import neuron_learn_layer_seq_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                  i_clock,
    input  logic                  i_valid,
    input  logic                  i_learn,
    input  zero2one_t [N-1:0]     i_in,
    input  zero2one_t             i_expected_out,
    output zero2one_t             o_out,
    output zero2one_t [N-1:0]     o_expected_in,
    output frac_t     [N-1:0]     o_weights,
    output frac_t                 o_activation_max,
    output frac_t                 o_activation_min
);

    localparam int unsigned SW = ZW + $clog2(N) + 1;

    logic [SW-1:0]        w_sum;
    zero2one_t            w_act;
    frac_t                w_act_f;
    frac_t                w_err;
    logic [ZW:0]          w_pair [N];
    zero2one_t [N-1:0]    w_back;

    zero2one_t            r_out;
    zero2one_t [N-1:0]    r_back;
    frac_t     [N-1:0]    r_weights;
    frac_t                r_act_max;
    frac_t                r_act_min;

    // Activation is the input mean; learned back-prop target pulls each
    // input halfway toward the neuron target.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = w_sum + SW'(i_in[j]);
        end
        w_act   = ZW'(w_sum / SW'(N));
        w_act_f = frac_t'(FW'(w_act));
        w_err   = frac_t'(FW'(i_expected_out)) - w_act_f;
        for (int j = 0; j < N; j++) begin
            w_pair[j] = {1'b0, i_in[j]} + {1'b0, i_expected_out};
            w_back[j] = i_learn ? w_pair[j][ZW:1] : i_in[j];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_valid) begin
            r_out     <= w_act;
            r_back    <= w_back;
            r_act_max <= (w_act_f > r_act_max) ? w_act_f : r_act_max;
            r_act_min <= (w_act_f < r_act_min) ? w_act_f : r_act_min;
            for (int j = 0; j < N; j++) begin
                if (i_learn && (i_in[j] != '0)) begin
                    r_weights[j] <= r_weights[j] + w_err;
                end
            end
        end
    end

    assign o_out            = r_out;
    assign o_expected_in    = r_back;
    assign o_weights        = r_weights;
    assign o_activation_max = r_act_max;
    assign o_activation_min = r_act_min;

endmodule

// File: rtl/zero2one_seq_average.sv
// Sequential M-way column average: one row per cycle into LEN accumulators.
//   i_clock  : rising-edge clock
//   i_reset  : asynchronous active-high reset, discards partial sums
//   i_start  : pulse; rows 0..M-1 are summed on the following M cycles
//   i_cols   : M rows of LEN values, row k read on cycle k
//   o_done_c : high on the cycle the final row is added
//   o_avg    : registered floor(sum/M) per column
module zero2one_seq_average
    import neuron_learn_layer_seq_pkg::*;
#(
    parameter int unsigned M   = 4,
    parameter int unsigned LEN = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  zero2one_t [M-1:0][LEN-1:0]    i_cols,
    output logic                          o_done_c,
    output zero2one_t [LEN-1:0]           o_avg
);

    localparam int unsigned SH    = $clog2(M);
    localparam int unsigned ACC_W = avg_acc_w(M);
    localparam int unsigned IDX_W = avg_idx_w(M);

    logic                 r_busy;
    logic [IDX_W-1:0]     r_idx;
    logic [ACC_W-1:0]     r_acc [LEN];
    zero2one_t [LEN-1:0]  r_avg;

    zero2one_t [LEN-1:0]  w_row;
    logic [ACC_W-1:0]     w_sum [LEN];
    logic                 w_last;

    assign w_last = r_busy && (r_idx == IDX_W'(M - 1));

    always_comb begin
        w_row = i_cols[r_idx];
        for (int j = 0; j < LEN; j++) begin
            w_sum[j] = r_acc[j] + ACC_W'(w_row[j]);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
            r_avg  <= '0;
            for (int j = 0; j < LEN; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
            end else if (w_last) begin
                r_busy <= 1'b0;
                r_idx  <= '0;
            end else if (r_busy) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // Last row: publish the shifted sum and leave accumulators clean.
            for (int j = 0; j < LEN; j++) begin
                if (w_last) begin
                    r_acc[j] <= '0;
                    r_avg[j] <= ZW'(w_sum[j] >> SH);
                end else if (r_busy) begin
                    r_acc[j] <= w_sum[j];
                end
            end
        end
    end

    assign o_done_c = w_last;
    assign o_avg    = r_avg;

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// Learning layer of M neurons with a valid/ready transaction wrapper.
//   i_clock / i_reset    : clock, asynchronous active-high reset
//   i_in_valid/o_in_ready: request handshake (ready only in IDLE)
//   i_learn, i_learn_mask: learn step and per-neuron learn enable
//   i_in, i_expected_out : layer inputs and per-neuron targets
//   o_out_valid/i_out_ready: result handshake (valid only in DONE)
//   o_out, o_expected_in : registered outputs and averaged back-prop targets
//   o_weights, o_activation_max/min: neuron pass-through
//   o_learn_count        : completed learn transactions, saturating
module neuron_learn_layer_seq
    import neuron_learn_layer_seq_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned M          = 4,
    parameter int unsigned NEURON_LAT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_learn,
    input  zero2one_t [N-1:0]          i_in,
    input  zero2one_t [M-1:0]          i_expected_out,
    input  logic [M-1:0]               i_learn_mask,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output zero2one_t [M-1:0]          o_out,
    output zero2one_t [N-1:0]          o_expected_in,
    output frac_t [M-1:0][N-1:0]       o_weights,
    output frac_t [M-1:0]              o_activation_max,
    output frac_t [M-1:0]              o_activation_min,
    output logic [CNT_W-1:0]           o_learn_count
);

    localparam int unsigned WAIT_W = $clog2(NEURON_LAT + 1);

    layer_state_t               r_state;
    layer_state_t               w_state_nxt;

    logic                       r_learn;
    logic [M-1:0]               r_mask;
    zero2one_t [N-1:0]          r_in;
    zero2one_t [M-1:0]          r_exp;
    logic [WAIT_W-1:0]          r_wait_cnt;
    zero2one_t [M-1:0]          r_out;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [CNT_W-1:0]           r_learn_count;

    logic                       w_capture;
    logic                       w_fire;
    logic                       w_wait_last;
    logic                       w_reduce_start;
    logic                       w_avg_done;
    logic                       w_count_en;
    zero2one_t [M-1:0]          w_neuron_out;
    zero2one_t [M-1:0][N-1:0]   w_unavg;

    assign w_wait_last = (r_wait_cnt == WAIT_W'(NEURON_LAT - 1));

    // Next-state and per-state strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        w_fire         = 1'b0;
        w_reduce_start = 1'b0;
        w_count_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = FIRE;
                end
            end
            FIRE: begin
                w_fire      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_wait_last) begin
                    if (r_learn) begin
                        w_reduce_start = 1'b1;
                        w_state_nxt    = REDUCE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            REDUCE: begin
                if (w_avg_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_count_en  = r_learn;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, wait timer, result and handshake registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_learn       <= 1'b0;
            r_mask        <= '0;
            r_in          <= '0;
            r_exp         <= '0;
            r_wait_cnt    <= '0;
            r_out         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_learn_count <= '0;
        end else begin
            if (w_capture) begin
                r_learn <= i_learn;
                r_mask  <= i_learn_mask;
                r_in    <= i_in;
                r_exp   <= i_expected_out;
            end
            if (r_state == FIRE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if ((r_state == WAIT) && w_wait_last) begin
                r_out <= w_neuron_out;
            end
            if (w_count_en && (r_learn_count != '1)) begin
                r_learn_count <= r_learn_count + CNT_W'(1);
            end
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_neuron
        neuron_learn #(
            .N (N)
        ) u_neuron (
            .i_clock          (i_clock),
            .i_valid          (w_fire),
            .i_learn          (w_fire & r_learn & r_mask[k]),
            .i_in             (r_in),
            .i_expected_out   (r_exp[k]),
            .o_out            (w_neuron_out[k]),
            .o_expected_in    (w_unavg[k]),
            .o_weights        (o_weights[k]),
            .o_activation_max (o_activation_max[k]),
            .o_activation_min (o_activation_min[k])
        );
    end

    zero2one_seq_average #(
        .M   (M),
        .LEN (N)
    ) u_avg (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (w_reduce_start),
        .i_cols   (w_unavg),
        .o_done_c (w_avg_done),
        .o_avg    (o_expected_in)
    );

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_out         = r_out;
    assign o_learn_count = r_learn_count;

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
module tb_neuron_learn_layer_seq;
    import neuron_learn_layer_seq_pkg::*;

    localparam int unsigned TN  = 4;
    localparam int unsigned TM  = 4;
    localparam int unsigned TNL = 1;
    localparam int unsigned TCW = 3;
    localparam int          CNT_MAX = (1 << TCW) - 1;

    logic                     clk;
    logic                     rst;
    logic                     i_in_valid;
    logic                     o_in_ready;
    logic                     i_learn;
    zero2one_t [TN-1:0]       i_in;
    zero2one_t [TM-1:0]       i_expected_out;
    logic [TM-1:0]            i_learn_mask;
    logic                     o_out_valid;
    logic                     i_out_ready;
    zero2one_t [TM-1:0]       o_out;
    zero2one_t [TN-1:0]       o_expected_in;
    frac_t [TM-1:0][TN-1:0]   o_weights;
    frac_t [TM-1:0]           o_activation_max;
    frac_t [TM-1:0]           o_activation_min;
    logic [TCW-1:0]           o_learn_count;

    neuron_learn_layer_seq #(
        .N(TN), .M(TM), .NEURON_LAT(TNL), .CNT_W(TCW)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_in_valid       (i_in_valid),
        .o_in_ready       (o_in_ready),
        .i_learn          (i_learn),
        .i_in             (i_in),
        .i_expected_out   (i_expected_out),
        .i_learn_mask     (i_learn_mask),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_out            (o_out),
        .o_expected_in    (o_expected_in),
        .o_weights        (o_weights),
        .o_activation_max (o_activation_max),
        .o_activation_min (o_activation_min),
        .o_learn_count    (o_learn_count)
    );

    typedef struct {
        int          rise;
        logic [63:0] out;
        logic [63:0] ei;
        int          cnt;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_pass = 0;
    int     n_total = 0;
    int     cyc = 0;
    int     bp_mode = 2;
    logic   mon_prev = 1'b0;

    // Reference state kept at transaction level.
    int     m_ei [TN];
    int     m_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Downstream ready: random, held low, or held high.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       i_out_ready = ($urandom_range(0, 3) != 0);
            1:       i_out_ready = 1'b0;
            default: i_out_ready = 1'b1;
        endcase
    end

    // Monitor: latency at out_valid rise, content at the output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_out_valid && !mon_prev) begin
                if (sb.size() == 0) chk("unexpected_valid", 64'(sb.size()), 64'd1);
                else chk("valid_latency", 64'(cyc), 64'(sb[0].rise));
            end
            if (o_out_valid) chk("in_ready_busy", 64'(o_in_ready), 64'd0);
            if (o_out_valid && i_out_ready && (sb.size() != 0)) begin
                mon_e = sb.pop_front();
                chk("out", 64'(o_out), mon_e.out);
                chk("expected_in", 64'(o_expected_in), mon_e.ei);
                chk("learn_count", 64'(o_learn_count), 64'(mon_e.cnt));
            end
        end
        mon_prev = rst ? 1'b0 : o_out_valid;
    end

    task automatic drive_txn(input logic lrn, input logic [TM-1:0] mask,
                             input zero2one_t [TN-1:0] iv, input zero2one_t [TM-1:0] ev,
                             output int acc_edge);
        int   guard;
        int   s;
        int   tot;
        int   u;
        exp_t e;
        @(negedge clk);
        i_in_valid     = 1'b1;
        i_learn        = lrn;
        i_learn_mask   = mask;
        i_in           = iv;
        i_expected_out = ev;
        guard = 0;
        while (!o_in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        acc_edge = cyc + 1;
        if (guard >= 300) begin
            chk("accept_timeout", 64'(guard), 64'd0);
            i_in_valid = 1'b0;
            return;
        end
        s = 0;
        for (int j = 0; j < TN; j++) s += int'(iv[j]);
        e.out = '0;
        for (int k = 0; k < TM; k++) e.out[k*8 +: 8] = 8'(s / TN);
        if (lrn) begin
            for (int j = 0; j < TN; j++) begin
                tot = 0;
                for (int k = 0; k < TM; k++) begin
                    u = mask[k] ? (int'(iv[j]) + int'(ev[k])) / 2 : int'(iv[j]);
                    tot += u;
                end
                m_ei[j] = tot / TM;
            end
        end
        e.ei = '0;
        for (int j = 0; j < TN; j++) e.ei[j*8 +: 8] = 8'(m_ei[j]);
        e.cnt  = m_count;
        e.rise = acc_edge + 1 + TNL + (lrn ? TM : 0);
        sb.push_back(e);
        if (lrn && m_count < CNT_MAX) m_count++;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !o_in_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", 64'(guard), 64'd0);
    endtask

    task automatic rand_vecs(output zero2one_t [TN-1:0] iv, output zero2one_t [TM-1:0] ev);
        for (int j = 0; j < TN; j++) iv[j] = 8'($urandom_range(0, 255));
        for (int k = 0; k < TM; k++) ev[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  64'(o_in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
        chk({tag, "_out"},       64'(o_out), 64'd0);
        chk({tag, "_ei"},        64'(o_expected_in), 64'd0);
        chk({tag, "_count"},     64'(o_learn_count), 64'd0);
    endtask

    initial begin
        zero2one_t [TN-1:0] iv;
        zero2one_t [TM-1:0] ev;
        int e_edge;
        int guard;

        for (int j = 0; j < TN; j++) m_ei[j] = 0;
        rst = 1'b1;
        i_in_valid = 1'b0;
        i_learn = 1'b0;
        i_learn_mask = '0;
        i_in = '0;
        i_expected_out = '0;
        i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // Inference then directed learn with known column values.
        rand_vecs(iv, ev);
        drive_txn(1'b0, 4'hF, iv, ev, e_edge);
        drain();
        rand_vecs(iv, ev);
        iv[0] = 8'h00;
        ev[0] = 8'h20; ev[1] = 8'h40; ev[2] = 8'h60; ev[3] = 8'h82;
        drive_txn(1'b1, 4'hF, iv, ev, e_edge);
        drain();
        chk("directed_avg_col0", 64'(o_expected_in[0]), 64'h28);
        rand_vecs(iv, ev);
        drive_txn(1'b1, 4'b0101, iv, ev, e_edge);
        drain();
        rand_vecs(iv, ev);
        drive_txn(1'b0, 4'hF, iv, ev, e_edge);
        drain();

        // Backpressure: hold DONE for 10 cycles while a second request waits.
        bp_mode = 1;
        rand_vecs(iv, ev);
        drive_txn(1'b1, 4'hF, iv, ev, e_edge);
        guard = 0;
        while (!o_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("bp_valid_timeout", 64'(guard), 64'd0);
        fork
            begin
                zero2one_t [TN-1:0] iv2;
                zero2one_t [TM-1:0] ev2;
                int e2;
                rand_vecs(iv2, ev2);
                drive_txn(1'b0, 4'hF, iv2, ev2, e2);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_valid_hold", 64'(o_out_valid), 64'd1);
                    chk("bp_out_stable", 64'(o_out), sb[0].out);
                    chk("bp_ei_stable", 64'(o_expected_in), sb[0].ei);
                end
                bp_mode = 2;
            end
        join
        drain();

        // Reset while the reduction is at row 2.
        rand_vecs(iv, ev);
        drive_txn(1'b1, 4'hF, iv, ev, e_edge);
        while (cyc < e_edge + 4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        for (int j = 0; j < TN; j++) m_ei[j] = 0;
        m_count = 0;
        chk_idle("midreset");
        @(negedge clk);
        rst = 1'b0;
        rand_vecs(iv, ev);
        drive_txn(1'b1, 4'hF, iv, ev, e_edge);
        drain();

        // Randomized traffic with random downstream readiness.
        bp_mode = 0;
        for (int t = 0; t < 40; t++) begin
            rand_vecs(iv, ev);
            drive_txn(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), iv, ev, e_edge);
        end
        bp_mode = 2;
        drain();
        chk("final_count", 64'(o_learn_count), 64'(m_count));
        chk("final_in_ready", 64'(o_in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
